// File: rtl/exception_ctrl_pkg.sv
// Shared exception-control definitions: exception codes, flag positions, CP0 bit fields and the
// interrupt-request helper.
package exception_ctrl_pkg;

  // Exception codes reported to CP0.
  typedef enum logic [2:0] {
    EXCEPT_NONE      = 3'd0,
    EXCEPT_INTERRUPT = 3'd1,
    EXCEPT_ILLEGAL   = 3'd2,
    EXCEPT_SYSCALL   = 3'd3,
    EXCEPT_TRAP      = 3'd4,
    EXCEPT_OVERFLOW  = 3'd5,
    EXCEPT_ERET      = 3'd6
  } exc_code_e;

  // Bit positions inside mem_exc_flags = {overflow, trap, illegal, syscall, eret}.
  localparam int unsigned CODE_ERET     = 0;
  localparam int unsigned CODE_SYSCALL  = 1;
  localparam int unsigned CODE_ILLEGAL  = 2;
  localparam int unsigned CODE_TRAP     = 3;
  localparam int unsigned CODE_OVERFLOW = 4;
  localparam int unsigned NUM_FLAGS     = 5;

  // CP0 Status / Cause fields.
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_TIMER  = 15;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } exc_state_e;

  // Timer request is merged into the highest Cause IP bit before masking.
  function automatic logic irq_request(logic [15:0] status, logic [15:0] cause, logic timer);
    logic [15:0] pend;
    pend              = cause;
    pend[CAUSE_TIMER] = cause[CAUSE_TIMER] | timer;
    return status[STATUS_IE] & ~status[STATUS_EXL] &
           |(pend[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]);
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// MEM-stage / CP0 side-band bundle between the pipeline and the exception controller.
interface exception_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_pc;
  logic [4:0]            mem_exc_flags;
  logic [DATA_WIDTH-1:0] cp0_status;
  logic [DATA_WIDTH-1:0] cp0_cause;
  logic [DATA_WIDTH-1:0] cp0_epc;
  logic                  timer_interrupt;
  logic [DATA_WIDTH-1:0] exception;
  logic [DATA_WIDTH-1:0] except_pc;
  logic                  flush;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] new_pc;

  modport master (
    output mem_valid, mem_pc, mem_exc_flags, cp0_status, cp0_cause, cp0_epc, timer_interrupt,
    input  exception, except_pc, flush, redirect, new_pc
  );

  modport slave (
    input  mem_valid, mem_pc, mem_exc_flags, cp0_status, cp0_cause, cp0_epc, timer_interrupt,
    output exception, except_pc, flush, redirect, new_pc
  );
endinterface

// File: rtl/exception_ctrl_prio_enc.sv
// Fixed-priority selection of the single reported exception:
// interrupt > illegal > syscall > trap > overflow > eret.
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic                 irq,
  input  logic [NUM_FLAGS-1:0] flags,
  output exc_code_e            code
);

  always_comb begin
    code = EXCEPT_NONE;
    if (irq) begin
      code = EXCEPT_INTERRUPT;
    end else if (flags[CODE_ILLEGAL]) begin
      code = EXCEPT_ILLEGAL;
    end else if (flags[CODE_SYSCALL]) begin
      code = EXCEPT_SYSCALL;
    end else if (flags[CODE_TRAP]) begin
      code = EXCEPT_TRAP;
    end else if (flags[CODE_OVERFLOW]) begin
      code = EXCEPT_OVERFLOW;
    end else if (flags[CODE_ERET]) begin
      code = EXCEPT_ERET;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: detects MEM-stage exceptions/interrupts, reports the winner to CP0,
// redirects fetch and flushes the pipeline for FLUSH_CYCLES cycles.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  exception_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_CYCLES);
  localparam int unsigned CODE_W   = $bits(exc_code_e);

  exc_state_e            state_q;
  logic [2:0]            cnt_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] exception_q;
  logic [DATA_WIDTH-1:0] except_pc_q;
  logic                  flush_q;
  logic                  redirect_q;
  logic [DATA_WIDTH-1:0] new_pc_q;

  logic      irq_req;
  logic      irq_any;
  logic      detect;
  logic      irq_taken;
  exc_code_e win_code;

  assign irq_req = irq_request(bus.cp0_status[15:0], bus.cp0_cause[15:0], bus.timer_interrupt);
  assign irq_any = pending_q | irq_req;

  exc_prio_enc u_prio (
    .irq   (irq_any),
    .flags (bus.mem_exc_flags),
    .code  (win_code)
  );

  // Interrupts only ride on a valid instruction, so mem_valid gates everything.
  assign detect    = (state_q == StIdle) && bus.mem_valid && (win_code != EXCEPT_NONE);
  assign irq_taken = detect && irq_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      exception_q <= '0;
      except_pc_q <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      new_pc_q    <= '0;
    end else begin
      pending_q   <= irq_req & ~irq_taken;
      exception_q <= '0;
      except_pc_q <= '0;
      redirect_q  <= 1'b0;
      new_pc_q    <= '0;
      unique case (state_q)
        StIdle: begin
          if (detect) begin
            state_q     <= StFlush;
            cnt_q       <= FLUSH_CNT;
            flush_q     <= 1'b1;
            exception_q <= {{(DATA_WIDTH - CODE_W){1'b0}}, win_code};
            except_pc_q <= bus.mem_pc;
            redirect_q  <= 1'b1;
            new_pc_q    <= (win_code == EXCEPT_ERET) ? bus.cp0_epc : EXC_VECTOR;
          end
        end
        StFlush: begin
          if (cnt_q == 3'd1) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.exception = exception_q;
  assign bus.except_pc = except_pc_q;
  assign bus.flush     = flush_q;
  assign bus.redirect  = redirect_q;
  assign bus.new_pc    = new_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed table, corner-case sequences and random
// stimulus against a cycle-level behavioural model.
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned FL  = 2;
  localparam logic [31:0] VEC = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exception_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  exception_ctrl #(
    .DATA_WIDTH   (DW),
    .EXC_VECTOR   (VEC),
    .FLUSH_CYCLES (FL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [4:0]  flags;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    bit          timer;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exc;
    logic [31:0] pc;
    logic [31:0] newpc;
    int          flush_n;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model state: flush cycles still to come (including the current one) and armed interrupt.
  int          m_flush_rem = 0;
  bit          m_pending   = 0;
  logic [31:0] e_exc       = '0;
  logic [31:0] e_pc        = '0;
  logic [31:0] e_newpc     = '0;
  bit          e_redir     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit valid, logic [31:0] pc, logic [4:0] flags, logic [31:0] status,
                             logic [31:0] cause, logic [31:0] epc, bit timer);
    in_t r;
    r.valid  = valid;
    r.pc     = pc;
    r.flags  = flags;
    r.status = status;
    r.cause  = cause;
    r.epc    = epc;
    r.timer  = timer;
    return r;
  endfunction

  // Priority expressed as an ordered list of {flag bit, code}.
  function automatic logic [31:0] pick(bit irq, logic [4:0] flags);
    int        order [5] = '{2, 1, 3, 4, 0};
    exc_code_e codes [5] = '{EXCEPT_ILLEGAL, EXCEPT_SYSCALL, EXCEPT_TRAP, EXCEPT_OVERFLOW,
                             EXCEPT_ERET};
    if (irq) return 32'(EXCEPT_INTERRUPT);
    for (int i = 0; i < 5; i++) begin
      if (flags[order[i]]) return 32'(codes[i]);
    end
    return 32'(EXCEPT_NONE);
  endfunction

  task automatic model_reset();
    m_flush_rem = 0;
    m_pending   = 0;
    e_exc       = '0;
    e_pc        = '0;
    e_newpc     = '0;
    e_redir     = 0;
  endtask

  // Apply one cycle of inputs, advance the model, then compare the registered outputs.
  task automatic drive(input in_t v);
    logic [7:0] ip;
    bit         irq;
    bit         take;
    bit         int_taken;
    bus.mem_valid       = v.valid;
    bus.mem_pc          = v.pc;
    bus.mem_exc_flags   = v.flags;
    bus.cp0_status      = v.status;
    bus.cp0_cause       = v.cause;
    bus.cp0_epc         = v.epc;
    bus.timer_interrupt = v.timer;

    ip        = v.cause[15:8] | {v.timer, 7'b0};
    irq       = v.status[0] && !v.status[1] && ((ip & v.status[15:8]) != 0);
    take      = (m_flush_rem == 0) && v.valid && (m_pending || irq || (v.flags != 0));
    int_taken = take && (m_pending || irq);
    if (take) begin
      e_exc       = pick(m_pending || irq, v.flags);
      e_pc        = v.pc;
      e_redir     = 1;
      e_newpc     = (e_exc == 32'(EXCEPT_ERET)) ? v.epc : VEC;
      m_flush_rem = FL;
    end else begin
      e_exc   = '0;
      e_pc    = '0;
      e_redir = 0;
      if (m_flush_rem > 0) m_flush_rem--;
    end
    m_pending = irq && !int_taken;

    @(posedge clk);
    #1;
    check("exception", bus.exception, e_exc);
    check("except_pc", bus.except_pc, e_pc);
    check("flush", 32'(bus.flush), 32'(m_flush_rem > 0));
    check("redirect", 32'(bus.redirect), 32'(e_redir));
    if (e_redir) check("new_pc", bus.new_pc, e_newpc);
  endtask

  in_t  idle;
  in_t  r;
  vec_t tbl [7];
  int   fl;

  initial begin
    idle = mk(0, 0, 5'b0, 0, 0, 0, 0);
    bus.mem_valid       = 1'b0;
    bus.mem_pc          = '0;
    bus.mem_exc_flags   = '0;
    bus.cp0_status      = '0;
    bus.cp0_cause       = '0;
    bus.cp0_epc         = '0;
    bus.timer_interrupt = 1'b0;

    // Directed table: single event, then idle while the flush drains.
    tbl[0] = '{mk(1, 32'h100, 5'b00010, 0, 0, 0, 0), 32'(EXCEPT_SYSCALL), 32'h100, VEC, 2};
    tbl[1] = '{mk(1, 32'h200, 5'b00010, 32'h8001, 0, 0, 1), 32'(EXCEPT_INTERRUPT), 32'h200,
               VEC, 2};
    tbl[2] = '{mk(1, 32'h180, 5'b00001, 0, 0, 32'h1234, 0), 32'(EXCEPT_ERET), 32'h180,
               32'h1234, 2};
    tbl[3] = '{mk(1, 32'h300, 5'b11100, 0, 0, 0, 0), 32'(EXCEPT_ILLEGAL), 32'h300, VEC, 2};
    tbl[4] = '{mk(1, 32'h304, 5'b11000, 0, 0, 0, 0), 32'(EXCEPT_TRAP), 32'h304, VEC, 2};
    tbl[5] = '{mk(1, 32'h308, 5'b10000, 0, 0, 0, 0), 32'(EXCEPT_OVERFLOW), 32'h308, VEC, 2};
    tbl[6] = '{mk(1, 32'h30c, 5'b00001, 32'h2, 0, 32'hbeef0, 0), 32'(EXCEPT_ERET), 32'h30c,
               32'hbeef0, 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_exception", bus.exception, 0);
    check("rst_except_pc", bus.except_pc, 0);
    check("rst_flush", 32'(bus.flush), 0);
    check("rst_redirect", 32'(bus.redirect), 0);
    check("rst_new_pc", bus.new_pc, 0);
    rst_n = 1'b1;
    model_reset();
    drive(idle);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].in);
      check("tbl_exc", bus.exception, tbl[i].exc);
      check("tbl_pc", bus.except_pc, tbl[i].pc);
      check("tbl_redirect", 32'(bus.redirect), 1);
      check("tbl_new_pc", bus.new_pc, tbl[i].newpc);
      fl = int'(bus.flush);
      repeat (3) begin
        drive(idle);
        fl += int'(bus.flush);
      end
      check("tbl_flush_cycles", fl, tbl[i].flush_n);
    end

    // Events during FLUSH are ignored; an interrupt raised there is taken once back in IDLE.
    drive(mk(1, 32'h400, 5'b00010, 0, 0, 0, 0));
    check("seqA_first", bus.exception, 32'(EXCEPT_SYSCALL));
    drive(mk(1, 32'h404, 5'b10000, 0, 0, 0, 0));
    check("seqA_ovf_ignored", bus.exception, 0);
    drive(mk(1, 32'h408, 5'b10000, 32'h8001, 0, 0, 1));
    check("seqA_irq_deferred", bus.exception, 0);
    drive(mk(1, 32'h40c, 5'b00000, 32'h8001, 0, 0, 1));
    check("seqA_irq_taken", bus.exception, 32'(EXCEPT_INTERRUPT));
    check("seqA_irq_pc", bus.except_pc, 32'h40c);
    repeat (3) drive(idle);

    // Interrupt waits for mem_valid; masked by EXL it is never taken.
    repeat (3) begin
      drive(mk(0, 32'h500, 5'b0, 32'h8001, 0, 0, 1));
      check("seqB_wait", bus.exception, 0);
    end
    drive(mk(1, 32'h504, 5'b0, 32'h8001, 0, 0, 0));
    check("seqB_taken", bus.exception, 32'(EXCEPT_INTERRUPT));
    repeat (3) drive(idle);
    repeat (3) begin
      drive(mk(1, 32'h508, 5'b0, 32'h8003, 0, 0, 1));
      check("seqB_exl_masked", bus.exception, 0);
    end
    repeat (2) drive(idle);

    // Reset during the first FLUSH cycle aborts the flush immediately.
    drive(mk(1, 32'h600, 5'b00010, 0, 0, 0, 0));
    check("seqC_flush_before", 32'(bus.flush), 1);
    rst_n = 1'b0;
    #1;
    check("seqC_flush_rst", 32'(bus.flush), 0);
    check("seqC_redirect_rst", 32'(bus.redirect), 0);
    check("seqC_exc_rst", bus.exception, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("seqC_flush_held", 32'(bus.flush), 0);
    rst_n = 1'b1;
    drive(idle);
    drive(mk(1, 32'h604, 5'b00100, 0, 0, 0, 0));
    check("seqC_idle_after", bus.exception, 32'(EXCEPT_ILLEGAL));
    repeat (3) drive(idle);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r.valid = ($urandom_range(9) < 7);
      r.pc    = $urandom & 32'hffff_fffc;
      for (int b = 0; b < 5; b++) r.flags[b] = ($urandom_range(5) == 0);
      case ($urandom_range(4))
        0:       r.status = 32'h0;
        1:       r.status = 32'h8001;
        2:       r.status = 32'hff01;
        3:       r.status = 32'h8003;
        default: r.status = $urandom;
      endcase
      r.cause = ($urandom_range(3) == 0) ? ($urandom & 32'h0000_ff00) : 32'h0;
      r.epc   = $urandom;
      r.timer = ($urandom_range(3) == 0);
      drive(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
